// File: rtl/bnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bnn_pkg
// Description : Shared types and constants for the BNN XNOR-popcount sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package bnn_pkg;

  localparam int BNN_WIDTH = 32;
  localparam int ACC_W     = 6;
  localparam logic [BNN_WIDTH-1:0] BIPOLAR_OFFSET = BNN_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } bnn_state_t;

  typedef enum logic [1:0] {
    POP     = 2'b00,
    BIPOLAR = 2'b01,
    THRESH  = 2'b10
  } bnn_mode_t;

  // Mode 11 is not encoded and falls through to the POP result.
  function automatic logic [BNN_WIDTH-1:0] bnn_result(
    input logic [1:0]       mode,
    input logic [ACC_W-1:0] p,
    input logic [ACC_W-1:0] thresh
  );
    logic [BNN_WIDTH-1:0] p_ext;
    p_ext = {{(BNN_WIDTH-ACC_W){1'b0}}, p};
    case (mode)
      BIPOLAR: return (p_ext << 1) - BIPOLAR_OFFSET;
      THRESH:  return {{(BNN_WIDTH-1){1'b0}}, (p >= thresh)};
      default: return p_ext;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/bnn_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : bnn_sequencer_if
// Description : Execute-stage request / result bundle for the BNN sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface bnn_sequencer_if;
  import bnn_pkg::*;

  logic                 StartE;
  logic                 FlushE;
  logic [1:0]           BNNModeE;
  logic [BNN_WIDTH-1:0] OpA;
  logic [BNN_WIDTH-1:0] OpB;
  logic [5:0]           ThreshE;
  logic                 StallBNN;
  logic                 Busy;
  logic                 BNNDone;
  logic [BNN_WIDTH-1:0] BNNResult;

  modport master (
    output StartE, FlushE, BNNModeE, OpA, OpB, ThreshE,
    input  StallBNN, Busy, BNNDone, BNNResult
  );

  modport slave (
    input  StartE, FlushE, BNNModeE, OpA, OpB, ThreshE,
    output StallBNN, Busy, BNNDone, BNNResult
  );
endinterface
`default_nettype wire

// File: rtl/popcount_chunk.sv
`default_nettype none
// ============================================================================
// Module      : popcount_chunk
// Description : Combinational population count of one CHUNK-bit slice.
// Revision    : 1.0 - initial release
// ============================================================================
module popcount_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0]        bits,
  output logic [$clog2(CHUNK):0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < CHUNK; i++) begin
      count = count + {{$clog2(CHUNK){1'b0}}, bits[i]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/bnn_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bnn_sequencer
// Description : Multi-cycle XNOR-popcount unit, CHUNK bits per cycle, stalls F/D/E.
// Revision    : 1.0 - initial release
// ============================================================================
module bnn_sequencer
  import bnn_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic          clk,
  input  logic          reset,
  bnn_sequencer_if.slave bus
);

  localparam int N_CHUNKS = BNN_WIDTH / CHUNK;
  localparam int K_W      = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam int CNT_W    = $clog2(CHUNK) + 1;

  bnn_state_t           r_state;
  logic [BNN_WIDTH-1:0] r_a;
  logic [BNN_WIDTH-1:0] r_b;
  logic [1:0]           r_mode;
  logic [ACC_W-1:0]     r_thresh;
  logic [ACC_W-1:0]     r_acc;
  logic [K_W-1:0]       r_k;
  logic [BNN_WIDTH-1:0] r_result;
  logic                 r_done;
  logic                 r_busy;

  logic [CHUNK-1:0]     w_chunk;
  logic [CNT_W-1:0]     w_cnt;
  logic [ACC_W-1:0]     w_sum;
  logic                 w_last;
  logic                 w_start;

  // Operands shift right each cycle, so the active chunk is always the low slice.
  assign w_chunk = ~(r_a[CHUNK-1:0] ^ r_b[CHUNK-1:0]);
  assign w_sum   = r_acc + ACC_W'(w_cnt);
  assign w_last  = (r_k == K_W'(N_CHUNKS - 1));
  assign w_start = (r_state == IDLE) && bus.StartE && !bus.FlushE;

  popcount_chunk #(
    .CHUNK (CHUNK)
  ) u_popcount (
    .bits  (w_chunk),
    .count (w_cnt)
  );

  assign bus.StallBNN  = reset && (w_start || (r_state == ACCUM));
  assign bus.Busy      = r_busy;
  assign bus.BNNDone   = r_done;
  assign bus.BNNResult = r_result;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_mode   <= '0;
      r_thresh <= '0;
      r_acc    <= '0;
      r_k      <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else if (bus.FlushE) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.StartE) begin
            r_a      <= bus.OpA;
            r_b      <= bus.OpB;
            r_mode   <= bus.BNNModeE;
            r_thresh <= bus.ThreshE;
            r_acc    <= '0;
            r_k      <= '0;
            r_busy   <= 1'b1;
            r_state  <= ACCUM;
          end
        end
        ACCUM: begin
          r_acc <= w_sum;
          r_k   <= r_k + K_W'(1);
          r_a   <= r_a >> CHUNK;
          r_b   <= r_b >> CHUNK;
          if (w_last) begin
            r_result <= bnn_result(r_mode, w_sum, r_thresh);
            r_done   <= 1'b1;
            r_state  <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bnn_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bnn_sequencer
// Description : Drives CHUNK=4/8/32 sequencers in lockstep against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bnn_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [1:0]  mode;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [5:0]  thresh;

  logic        stall_o [3];
  logic        busy_o  [3];
  logic        done_o  [3];
  logic [31:0] res_o   [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CH = (g == 0) ? 4 : (g == 1) ? 8 : 32;
    bnn_sequencer_if bus ();
    assign bus.StartE   = start;
    assign bus.FlushE   = flush;
    assign bus.BNNModeE = mode;
    assign bus.OpA      = op_a;
    assign bus.OpB      = op_b;
    assign bus.ThreshE  = thresh;
    assign stall_o[g]   = bus.StallBNN;
    assign busy_o[g]    = bus.Busy;
    assign done_o[g]    = bus.BNNDone;
    assign res_o[g]     = bus.BNNResult;

    bnn_sequencer #(
      .CHUNK (CH)
    ) u_dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
    );
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int          chunk_of [3] = '{4, 8, 32};
  int          start_cyc [3];
  logic [31:0] held [3];
  logic [31:0] pend [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] m, input logic [31:0] a,
                                             input logic [31:0] b, input logic [5:0] t);
    int p;
    p = $countones(~(a ^ b));
    case (m)
      2'b01:   return 2 * p - 32;
      2'b10:   return (p >= int'(t)) ? 32'd1 : 32'd0;
      default: return p;
    endcase
  endfunction

  // One clock cycle: apply inputs, check at the falling edge, advance model at the rising edge.
  task automatic step(input logic r, input logic s, input logic f, input logic [1:0] m,
                      input logic [31:0] a, input logic [31:0] b, input logic [5:0] t);
    rst_n = r; start = s; flush = f; mode = m; op_a = a; op_b = b; thresh = t;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      int   n, ph;
      logic in_op, accum, done, idle;
      n     = 32 / chunk_of[d];
      in_op = (start_cyc[d] >= 0);
      ph    = in_op ? cyc - start_cyc[d] : 0;
      accum = in_op && ph >= 1 && ph <= n;
      done  = in_op && ph == n + 1;
      idle  = !(accum || done);
      check($sformatf("c%0d_stall", chunk_of[d]), 32'(stall_o[d]),
            32'(r && ((idle && s && !f) || accum)));
      check($sformatf("c%0d_busy", chunk_of[d]), 32'(busy_o[d]), 32'(r && (accum || done)));
      check($sformatf("c%0d_done", chunk_of[d]), 32'(done_o[d]), 32'(r && done));
      check($sformatf("c%0d_result", chunk_of[d]), res_o[d],
            !r ? 32'd0 : (done ? pend[d] : held[d]));
    end
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      int   n, ph;
      logic in_op, done;
      n     = 32 / chunk_of[d];
      in_op = (start_cyc[d] >= 0);
      ph    = in_op ? cyc - start_cyc[d] : 0;
      done  = in_op && ph == n + 1;
      if (!r) begin
        start_cyc[d] = -1;
        held[d]      = '0;
      end else if (done) begin
        held[d]      = pend[d];
        start_cyc[d] = -1;
      end else if (f) begin
        start_cyc[d] = -1;
      end else if (!in_op && s) begin
        start_cyc[d] = cyc;
        pend[d]      = ref_result(m, a, b, t);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle_steps(input int count);
    for (int i = 0; i < count; i++) step(1'b1, 1'b0, 1'b0, 2'b00, '0, '0, '0);
  endtask

  task automatic op(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                    input logic [5:0] t);
    step(1'b1, 1'b1, 1'b0, m, a, b, t);
    idle_steps(9);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      start_cyc[d] = -1;
      held[d]      = '0;
      pend[d]      = '0;
    end
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; mode = '0; op_a = '0; op_b = '0; thresh = '0;
    @(posedge clk);
    #1;

    // Reset state, including a StartE that must not stall while in reset.
    step(1'b0, 1'b1, 1'b0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd0);
    step(1'b0, 1'b0, 1'b0, 2'b00, '0, '0, '0);

    // Directed modes and boundaries.
    op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd0);
    op(2'b01, 32'h0000FFFF, 32'hFFFFFFFF, 6'd0);
    op(2'b01, 32'h0000FFFF, 32'h0000FFFF, 6'd0);
    op(2'b10, 32'h0F0F0F0F, 32'h0F0F0F0F, 6'd32);
    op(2'b10, 32'h00000000, 32'hFFFFFFFF, 6'd1);
    op(2'b11, 32'h12345678, 32'h0F0F00FF, 6'd0);
    op(2'b01, 32'h00000000, 32'hFFFFFFFF, 6'd0);

    // Flush during the second ACCUM cycle.
    step(1'b1, 1'b1, 1'b0, 2'b00, 32'hAAAA5555, 32'h5555AAAA, 6'd0);
    idle_steps(1);
    step(1'b1, 1'b0, 1'b1, 2'b00, '0, '0, '0);
    idle_steps(10);

    // Flush and start together in IDLE.
    step(1'b1, 1'b1, 1'b1, 2'b00, 32'hFFFFFFFF, 32'h0, 6'd0);
    idle_steps(2);

    // StartE held high: ignored while busy, re-accepted the cycle after DONE.
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b1, 1'b0, 2'(i % 3), 32'hDEAD0000 + 32'(i), 32'hBEEF1234 ^ 32'(i * 7), 6'(i + 10));
    idle_steps(10);

    // Reset asserted mid-ACCUM, then released.
    step(1'b1, 1'b1, 1'b0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd0);
    idle_steps(1);
    step(1'b0, 1'b0, 1'b0, 2'b00, '0, '0, '0);
    step(1'b0, 1'b0, 1'b0, 2'b00, '0, '0, '0);
    idle_steps(10);
    op(2'b00, 32'hF0F0F0F0, 32'hFFFF0000, 6'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? a : $urandom;
      if ($urandom_range(0, 9) == 0) a = 32'hFFFFFFFF;
      step(($urandom_range(0, 63) != 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 15) == 0),
           2'($urandom_range(0, 3)), a, b, 6'($urandom_range(0, 63)));
    end
    idle_steps(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
